// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb: DEPTH x DATA_W register file with a per-register busy scoreboard.
//
// It has one write port and two registered read ports. The read ports use
// write-first bypass. The scoreboard lets the control unit track pending
// writebacks and stall on read-after-write hazards.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   addr1, addr2          read addresses (sampled each edge)
//   addrw, din, write     write port
//   claim, claim_addr     mark a register as pending writeback
//   out1, out2            registered read data (1-cycle latency)
//   busy1, busy2          registered post-update busy flag of the read register
//   claim_conflict        one-cycle pulse: claim hit an already-busy register
//   busy_vec              scoreboard, bit i = register i busy
//
// Optional feature (macro REG_FILE_ZERO_REG_EN): register 0 reads as zero.
// Writes and claims to register 0 are discarded, and register 0 is never busy.
// -----------------------------------------------------------------------------
module reg_file_sb #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [ADDR_W-1:0] addrw,
    input  logic [DATA_W-1:0] din,
    input  logic              write,
    input  logic              claim,
    input  logic [ADDR_W-1:0] claim_addr,
    output logic [DATA_W-1:0] out1,
    output logic [DATA_W-1:0] out2,
    output logic              busy1,
    output logic              busy2,
    output logic              claim_conflict,
    output logic [DEPTH-1:0]  busy_vec
);

    localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(DEPTH);

    // An address takes part in reads, writes and claims only if it maps to a
    // real register. With the zero register, address 0 is excluded as well.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        logic ok;
        ok = ({1'b0, a} < DepthLim);
`ifdef REG_FILE_ZERO_REG_EN
        ok = ok && (a != '0);
`endif
        return ok;
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DATA_W-1:0] out1_q, out1_d, out2_q, out2_d;
    logic              busy1_q, busy1_d, busy2_q, busy2_d;
    logic              conflict_q, conflict_d;

    logic wr_ok, claim_ok, rd1_ok, rd2_ok;

    always_comb begin
        wr_ok    = write && addr_ok(addrw);
        claim_ok = claim && addr_ok(claim_addr);
        rd1_ok   = addr_ok(addr1);
        rd2_ok   = addr_ok(addr2);

        mem_d = mem_q;
        if (wr_ok) mem_d[addrw] = din;

        // Claim takes priority over a clearing write to the same register.
        busy_d = busy_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (claim_ok && claim_addr == ADDR_W'(i)) begin
                busy_d[i] = 1'b1;
            end else if (wr_ok && addrw == ADDR_W'(i)) begin
                busy_d[i] = 1'b0;
            end
        end

        out1_d  = '0;
        busy1_d = 1'b0;
        if (rd1_ok) begin
            out1_d  = (wr_ok && addrw == addr1) ? din : mem_q[addr1];
            busy1_d = busy_d[addr1];
        end

        out2_d  = '0;
        busy2_d = 1'b0;
        if (rd2_ok) begin
            out2_d  = (wr_ok && addrw == addr2) ? din : mem_q[addr2];
            busy2_d = busy_d[addr2];
        end

        // A same-cycle write to the claimed register counts as retiring the old
        // claim, so no conflict is reported.
        conflict_d = claim_ok && busy_q[claim_addr] && !(wr_ok && addrw == claim_addr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            busy_q     <= '0;
            out1_q     <= '0;
            out2_q     <= '0;
            busy1_q    <= 1'b0;
            busy2_q    <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= mem_d[i];
            busy_q     <= busy_d;
            out1_q     <= out1_d;
            out2_q     <= out2_d;
            busy1_q    <= busy1_d;
            busy2_q    <= busy2_d;
            conflict_q <= conflict_d;
        end
    end

    assign out1           = out1_q;
    assign out2           = out2_q;
    assign busy1          = busy1_q;
    assign busy2          = busy2_q;
    assign claim_conflict = conflict_q;
    assign busy_vec       = busy_q;

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

`ifdef REG_FILE_ZERO_REG_EN
    localparam bit ZeroReg = 1'b1;
`else
    localparam bit ZeroReg = 1'b0;
`endif

    logic       clk, rst_n;
    logic [2:0] addr1, addr2, addrw, claim_addr;
    logic [7:0] din;
    logic       write, claim;
    logic [7:0] out1, out2;
    logic       busy1, busy2, claim_conflict;
    logic [7:0] busy_vec;

    reg_file_sb #(.DATA_W(8), .ADDR_W(3), .DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .addr1(addr1), .addr2(addr2), .addrw(addrw),
        .din(din), .write(write), .claim(claim), .claim_addr(claim_addr),
        .out1(out1), .out2(out2), .busy1(busy1), .busy2(busy2),
        .claim_conflict(claim_conflict), .busy_vec(busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] out1;
        logic [7:0] out2;
        logic       busy1;
        logic       busy2;
        logic       conf;
        logic [7:0] bv;
    } exp_t;

    exp_t       sb_q[$];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] ref_mem [8];
    logic [7:0] ref_busy;

    // Scoreboard: one expectation per driven cycle, compared just after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks += 6;
            if (out1 !== e.out1) begin
                errors++; $display("FAIL sb_out1 t=%0t got %h want %h", $time, out1, e.out1);
            end
            if (out2 !== e.out2) begin
                errors++; $display("FAIL sb_out2 t=%0t got %h want %h", $time, out2, e.out2);
            end
            if (busy1 !== e.busy1) begin
                errors++; $display("FAIL sb_busy1 t=%0t got %b want %b", $time, busy1, e.busy1);
            end
            if (busy2 !== e.busy2) begin
                errors++; $display("FAIL sb_busy2 t=%0t got %b want %b", $time, busy2, e.busy2);
            end
            if (claim_conflict !== e.conf) begin
                errors++;
                $display("FAIL sb_conflict t=%0t got %b want %b", $time, claim_conflict, e.conf);
            end
            if (busy_vec !== e.bv) begin
                errors++; $display("FAIL sb_busy_vec t=%0t got %h want %h", $time, busy_vec, e.bv);
            end
        end
    end

    function automatic logic usable(input logic [2:0] a);
        return !(ZeroReg && a == 3'd0);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;
        ref_busy = 8'h00;
    endtask

    // Drive one cycle (called at a negedge), push the model's expectation,
    // then return at the next negedge.
    task automatic step(input logic wr, input logic [2:0] aw, input logic [7:0] d,
                        input logic cl, input logic [2:0] ca,
                        input logic [2:0] a1, input logic [2:0] a2);
        exp_t       e;
        logic       wv, cv;
        logic [7:0] nb;
        write = wr; addrw = aw; din = d; claim = cl; claim_addr = ca;
        addr1 = a1; addr2 = a2;
        wv = wr && usable(aw);
        cv = cl && usable(ca);
        nb = ref_busy;
        if (wv) nb[aw] = 1'b0;
        if (cv) nb[ca] = 1'b1;
        e.out1  = !usable(a1) ? 8'h00 : (wv && aw == a1) ? d : ref_mem[a1];
        e.out2  = !usable(a2) ? 8'h00 : (wv && aw == a2) ? d : ref_mem[a2];
        e.busy1 = usable(a1) ? nb[a1] : 1'b0;
        e.busy2 = usable(a2) ? nb[a2] : 1'b0;
        e.conf  = cv && ref_busy[ca] && !(wv && aw == ca);
        e.bv    = nb;
        sb_q.push_back(e);
        if (wv) ref_mem[aw] = d;
        ref_busy = nb;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd0);
    endtask

    task automatic check_all_zero(input string tag);
        checks += 6;
        if (out1 !== 8'h00 || out2 !== 8'h00 || busy1 !== 1'b0 || busy2 !== 1'b0 ||
            claim_conflict !== 1'b0 || busy_vec !== 8'h00) begin
            errors += 1;
            $display("FAIL %s got out1=%h out2=%h b1=%b b2=%b cc=%b bv=%h want all zero",
                     tag, out1, out2, busy1, busy2, claim_conflict, busy_vec);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        write = 0; claim = 0; addrw = 0; din = 0; claim_addr = 0; addr1 = 0; addr2 = 0;
        #12;
        check_all_zero("reset_state");
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd3, 3'd7);
    endtask

    task automatic test_write_bypass();
        step(1'b1, 3'd5, 8'hA5, 1'b0, 3'd0, 3'd5, 3'd0);
        checks++;
        if (out1 !== 8'hA5) begin errors++; $display("FAIL bypass got %h want a5", out1); end
        step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd5, 3'd0);
        checks++;
        if (out1 !== 8'hA5) begin errors++; $display("FAIL hold_read got %h want a5", out1); end
    endtask

    task automatic test_claim_clear();
        step(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 3'd0, 3'd2);
        checks += 2;
        if (busy_vec !== 8'h04) begin errors++; $display("FAIL claim_vec got %h want 04", busy_vec); end
        if (busy2 !== 1'b1) begin errors++; $display("FAIL claim_busy2 got %b want 1", busy2); end
        step(1'b1, 3'd2, 8'h3C, 1'b0, 3'd0, 3'd0, 3'd2);
        checks += 3;
        if (out2 !== 8'h3C) begin errors++; $display("FAIL wb_out2 got %h want 3c", out2); end
        if (busy2 !== 1'b0) begin errors++; $display("FAIL wb_busy2 got %b want 0", busy2); end
        if (busy_vec !== 8'h00) begin errors++; $display("FAIL wb_vec got %h want 00", busy_vec); end
    endtask

    task automatic test_claim_conflict();
        step(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 3'd4, 3'd0);
        checks++;
        if (claim_conflict !== 1'b0) begin errors++; $display("FAIL first_claim got 1 want 0"); end
        step(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 3'd4, 3'd0);
        checks += 2;
        if (claim_conflict !== 1'b1) begin errors++; $display("FAIL second_claim got 0 want 1"); end
        if (busy_vec !== 8'h10) begin errors++; $display("FAIL conflict_vec got %h want 10", busy_vec); end
        idle();
        checks++;
        if (claim_conflict !== 1'b0) begin errors++; $display("FAIL conflict_pulse got 1 want 0"); end
        step(1'b1, 3'd4, 8'h5A, 1'b1, 3'd4, 3'd4, 3'd4);
        checks += 3;
        if (busy_vec[4] !== 1'b1) begin errors++; $display("FAIL claim_wins got 0 want 1"); end
        if (claim_conflict !== 1'b0) begin errors++; $display("FAIL claim_write_conf got 1 want 0"); end
        if (out1 !== 8'h5A) begin errors++; $display("FAIL claim_write_data got %h want 5a", out1); end
        step(1'b1, 3'd4, 8'h5A, 1'b0, 3'd0, 3'd4, 3'd0);
    endtask

    task automatic test_reset_mid_write();
        step(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 3'd5, 3'd3);
        write = 1'b1; addrw = 3'd1; din = 8'hFF;
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd1, 3'd5);
        checks++;
        if (out1 !== 8'h00) begin errors++; $display("FAIL lost_write got %h want 00", out1); end
    endtask

    task automatic test_zero_reg();
        step(1'b1, 3'd0, 8'h77, 1'b1, 3'd0, 3'd0, 3'd0);
        idle();
        checks += 3;
`ifdef REG_FILE_ZERO_REG_EN
        if (out1 !== 8'h00) begin errors++; $display("FAIL zero_out1 got %h want 00", out1); end
        if (busy1 !== 1'b0) begin errors++; $display("FAIL zero_busy1 got %b want 0", busy1); end
        if (busy_vec[0] !== 1'b0) begin errors++; $display("FAIL zero_vec got 1 want 0"); end
`else
        if (out1 !== 8'h77) begin errors++; $display("FAIL reg0_out1 got %h want 77", out1); end
        if (busy1 !== 1'b1) begin errors++; $display("FAIL reg0_busy1 got %b want 1", busy1); end
        if (busy_vec !== 8'h01) begin errors++; $display("FAIL reg0_vec got %h want 01", busy_vec); end
`endif
        step(1'b1, 3'd0, 8'h77, 1'b0, 3'd0, 3'd0, 3'd0);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 80; n++) begin
            step(1'($urandom_range(1)), 3'($urandom_range(7)), 8'($urandom),
                 1'($urandom_range(3) == 0), 3'($urandom_range(7)),
                 3'($urandom_range(7)), 3'($urandom_range(7)));
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_bypass();
        test_claim_clear();
        test_claim_conflict();
        test_reset_mid_write();
        test_zero_reg();
        test_back_to_back();
        @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the team's 8x8 register bank: DEPTH x DATA_W storage, one write port, two read ports.
- Read ports are registered with write-first bypass.
- Adds a per-register busy scoreboard so the control unit can track pending writebacks and stall on read-after-write hazards.
- Sits between decode (read/claim addresses) and writeback (write port) in the CPU datapath.

Parameters:
- DATA_W, 8, register width in bits.
- ADDR_W, 3, address width.
- DEPTH, 8, number of registers; must be <= 2**ADDR_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- addr1  in  ADDR_W  read port 1 address.
- addr2  in  ADDR_W  read port 2 address.
- addrw  in  ADDR_W  write address.
- din  in  DATA_W  write data.
- write  in  1  write enable.
- claim  in  1  mark register claim_addr as pending.
- claim_addr  in  ADDR_W  register to claim.
- out1  out  DATA_W  registered read data, port 1.
- out2  out  DATA_W  registered read data, port 2.
- busy1  out  1  registered busy flag of the register read on port 1.
- busy2  out  1  registered busy flag of the register read on port 2.
- claim_conflict  out  1  one-cycle pulse: claim hit an already-busy register.
- busy_vec  out  DEPTH  current scoreboard, bit i = register i busy.

Behaviour:
- Reset (rst_n=0, asynchronous, any time): all registers = 0, busy_vec = 0, out1/out2 = 0, busy1/busy2 = 0, claim_conflict = 0. Reset mid-write: the write is lost. Release is synchronous to the next edge.
- Write: if write=1 and addrw < DEPTH, reg[addrw] <= din at the edge. Writes with addrw >= DEPTH are ignored.
- Read latency is 1 cycle: out1 at edge N+1 reflects addr1 sampled at edge N. Reads occur every cycle; there is no read enable.
- Bypass, write-first: if write=1 and addrw==addr1 (valid address) in the same cycle, out1 <= din, not the old value. The same rule applies to port 2. Both ports may hit the same address and both receive din.
- Out-of-range read (addr >= DEPTH): out = 0, busy = 0.
- Scoreboard update each edge, per register i:
  - set if claim=1 and claim_addr==i;
  - else clear if write=1 and addrw==i;
  - else hold.
- Simultaneous claim and write to the same register: claim wins, busy stays/becomes 1, and the data is still written.
- Claims with claim_addr >= DEPTH are ignored.
- busy1/busy2: registered, and reflect the post-update scoreboard for the sampled address. A read coinciding with a clearing write returns busy=0 with the bypassed data. A read coinciding with a claim returns busy=1.
- claim_conflict <= 1 for one cycle when claim=1 and busy_vec[claim_addr] was already 1 before the edge, unless a same-cycle write to that address clears it. The register stays busy either way.
- busy_vec is the scoreboard register itself, with no extra latency.

Optional Feature:
- Macro: REG_FILE_ZERO_REG_EN.
- Defined: register 0 is hardwired to zero.
  - Writes to address 0 are discarded, and bypass never forwards din for address 0.
  - Reads of address 0 always return 0 with busy=0.
  - Claims of address 0 are ignored; busy_vec[0] is constant 0 and no claim_conflict is raised.
- Not defined: register 0 behaves like every other register.

Test Plan (DATA_W=8, ADDR_W=3, DEPTH=8):
1. Reset, then read addr1=3, addr2=7 -> next cycle out1=0x00, out2=0x00, busy_vec=0x00.
2. Write din=0xA5, addrw=5, with addr1=5 in the same cycle -> next cycle out1=0xA5 via bypass. Hold addr1=5, write=0 -> out1 stays 0xA5.
3. claim=1, claim_addr=2 -> busy_vec=0x04. Read addr2=2 -> busy2=1. Write addrw=2, din=0x3C, with addr2=2 -> next cycle out2=0x3C, busy2=0, busy_vec=0x00.
4. Claim 4 twice in consecutive cycles -> busy_vec=0x10, claim_conflict=1 for exactly one cycle after the second claim. Claim 4 plus write 4 in the same cycle -> busy_vec bit 4 stays 1, reg4=din, no conflict.
5. Assert rst_n=0 mid-cycle while write=1, addrw=1, din=0xFF -> outputs and busy_vec go to 0 immediately. After release, reading addr 1 returns 0x00.
6. With REG_FILE_ZERO_REG_EN defined: write addrw=0, din=0x77, claim 0, read addr1=0 -> out1=0x00, busy1=0, busy_vec[0]=0. Without the macro -> out1=0x77, busy_vec=0x01.
